// File: rtl/aes_pkg.sv
// Shared definitions for the AES feed scheduler: mux select encoding and FSM states.
package aes_pkg;

  localparam logic [1:0] SEL_KEY  = 2'd0;
  localparam logic [1:0] SEL_IV   = 2'd1;
  localparam logic [1:0] SEL_CT   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_IV,
    ST_CHAIN,
    ST_DRAIN
  } aes_feed_state_e;

endpackage

// File: rtl/aes_feed_sched.sv
// Steers the AES share mux through key, IV and per-block chaining sources for a job.
// Optional macro AES_CBC_CHAIN_EN: CHAIN feeds back ciphertext instead of a fresh IV per block.
module aes_feed_sched
  import aes_pkg::*;
#(
  parameter int unsigned SHARES = 3,
  parameter int unsigned NBLK_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [NBLK_W-1:0] nblk_i,
  input  logic              abort_i,
  input  logic              wvalid_i,
  input  logic              ivalid_i,
  input  logic              cvalid_i,
  input  logic              dst_ready_i,
  output logic [1:0]        sel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [NBLK_W-1:0] blk_cnt_o
);

  if (SHARES < 1) begin : g_bad_shares
    $error("aes_feed_sched: SHARES must be at least 1");
  end

  aes_feed_state_e   state_q, state_d;
  logic [NBLK_W-1:0] cnt_q, cnt_d;
  logic [NBLK_W-1:0] nblk_q, nblk_d;
  logic              done_q, done_d;

  logic [1:0] chain_sel;
  logic       chain_valid;

`ifdef AES_CBC_CHAIN_EN
  assign chain_sel   = SEL_CT;
  assign chain_valid = cvalid_i;
`else
  assign chain_sel   = SEL_IV;
  assign chain_valid = ivalid_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nblk_d  = nblk_q;
    done_d  = 1'b0;
    sel_o   = SEL_NONE;

    unique case (state_q)
      ST_IDLE: begin
        sel_o = SEL_NONE;
        if (start_i) begin
          if (nblk_i == '0) begin
            done_d = 1'b1;
          end else begin
            nblk_d  = nblk_i;
            cnt_d   = '0;
            state_d = ST_KEY;
          end
        end
      end
      ST_KEY: begin
        sel_o = SEL_KEY;
        if (wvalid_i && dst_ready_i) state_d = ST_IV;
      end
      ST_IV: begin
        sel_o = SEL_IV;
        if (ivalid_i && dst_ready_i) begin
          cnt_d   = cnt_q + NBLK_W'(1);
          state_d = (nblk_q == NBLK_W'(1)) ? ST_DRAIN : ST_CHAIN;
        end
      end
      ST_CHAIN: begin
        sel_o = chain_sel;
        if (chain_valid && dst_ready_i) begin
          cnt_d = cnt_q + NBLK_W'(1);
          if (cnt_d == nblk_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last ciphertext is consumed regardless of the core's ready.
        sel_o = SEL_CT;
        if (cvalid_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        sel_o   = SEL_NONE;
        state_d = ST_IDLE;
      end
    endcase

    if (abort_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      nblk_d  = nblk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nblk_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nblk_q  <= nblk_d;
      done_q  <= done_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign blk_cnt_o = cnt_q;

endmodule

// File: tb/tb_aes_feed_sched.sv
// Scoreboard bench for aes_feed_sched: an item-index job model predicts outputs each cycle.
module tb_aes_feed_sched;

  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] nblk;
  logic          abort;
  logic          wvalid, ivalid, cvalid, rdy;
  logic [1:0]    sel;
  logic          busy, done;
  logic [NW-1:0] cnt;

  aes_feed_sched #(.SHARES(3), .NBLK_W(NW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .nblk_i     (nblk),
    .abort_i    (abort),
    .wvalid_i   (wvalid),
    .ivalid_i   (ivalid),
    .cvalid_i   (cvalid),
    .dst_ready_i(rdy),
    .sel_o      (sel),
    .busy_o     (busy),
    .done_o     (done),
    .blk_cnt_o  (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    sel;
    logic          busy;
    logic          done;
    logic [NW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   running = 1'b1;

  // Job model: k counts items moved so far (0 key, 1 IV, 2..n chain blocks, n+1 drain).
  bit m_active;
  int m_k, m_n, m_cnt;
  bit m_done;

`ifdef AES_CBC_CHAIN_EN
  localparam logic [1:0] CHAIN_SEL = 2'd2;
`else
  localparam logic [1:0] CHAIN_SEL = 2'd1;
`endif

  function automatic logic [1:0] model_sel();
    if (!m_active)      return 2'd3;
    if (m_k == 0)       return 2'd0;
    if (m_k == 1)       return 2'd1;
    if (m_k <= m_n)     return CHAIN_SEL;
    return 2'd2;
  endfunction

  task automatic model_step();
    bit src_ok;
    if (!rst_n) begin
      m_active = 0; m_k = 0; m_n = 0; m_cnt = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (abort) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        if (nblk == 0) m_done = 1;
        else begin m_active = 1; m_n = int'(nblk); m_k = 0; m_cnt = 0; end
      end
    end else if (m_k == m_n + 1) begin
      if (cvalid) begin m_active = 0; m_done = 1; end
    end else begin
      if (m_k == 0)      src_ok = wvalid;
      else if (m_k == 1) src_ok = ivalid;
      else               src_ok = (CHAIN_SEL == 2'd2) ? cvalid : ivalid;
      if (src_ok && rdy) begin
        m_k++;
        if (m_k >= 2) m_cnt = m_k - 1;
      end
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    e.sel  = model_sel();
    e.busy = m_active;
    e.done = m_done;
    e.cnt  = NW'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic all_high();
    wvalid = 1; ivalid = 1; cvalid = 1; rdy = 1;
  endtask

  task automatic go(input int n_blocks);
    start = 1; nblk = NW'(n_blocks);
    cyc();
    start = 0;
  endtask

  // Monitor: compare every cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    while (running || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sel !== e.sel || busy !== e.busy || done !== e.done || cnt !== e.cnt) begin
          errors++;
          $display("FAIL outputs @%0t: got sel=%0d busy=%0b done=%0b cnt=%0d, want sel=%0d busy=%0b done=%0b cnt=%0d",
                   $time, sel, busy, done, cnt, e.sel, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n = 0; start = 0; nblk = '0; abort = 0;
    wvalid = 0; ivalid = 0; cvalid = 0; rdy = 0;
    run(3);
    rst_n = 1;
    run(2);

    // Three-block job with everything ready.
    all_high();
    go(3);
    run(7);

    // Single block: key, IV, drain.
    go(1);
    run(5);

    // Ready withdrawn for four cycles while chaining.
    go(3);
    run(3);
    rdy = 0;
    run(4);
    rdy = 1;
    run(6);

    // Abort mid-chain at count 2, then a fresh job.
    go(5);
    run(3);
    abort = 1;
    cyc();
    abort = 0;
    run(2);
    go(2);
    run(6);

    // Zero-length job, then start held during a running job.
    go(0);
    run(3);
    go(3);
    start = 1; nblk = NW'(7);
    run(2);
    start = 0;
    run(6);

    // Two-block job for chain source selection.
    go(2);
    run(6);

    // Maximum block count.
    go(15);
    run(20);

    // Reset mid-job.
    go(4);
    run(3);
    rst_n = 0;
    cyc();
    rst_n = 1;
    run(3);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      wvalid = ($urandom_range(0, 3) != 0);
      ivalid = ($urandom_range(0, 3) != 0);
      cvalid = ($urandom_range(0, 3) != 0);
      rdy    = ($urandom_range(0, 3) != 0);
      abort  = ($urandom_range(0, 60) == 0);
      rst_n  = ($urandom_range(0, 400) != 0);
      start  = ($urandom_range(0, 5) == 0);
      nblk   = ($urandom_range(0, 9) == 0) ? NW'(15) : NW'($urandom_range(0, 5));
      cyc();
    end
    abort = 0; start = 0; rst_n = 1;
    run(2);

    running = 0;
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_feed_sched.md
AES_FEED_SCHED -- requirements
Module: aes_feed_sched

Interface
REQ-001 Parameter SHARES, default 3: number of masking shares in the mux this block steers; affects no port width here and is kept for instantiation symmetry.
REQ-002 Parameter NBLK_W, default 16: width of the block-count ports.
REQ-003 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 Port start_i, input, 1: begin a job; sampled only in IDLE.
REQ-006 Port nblk_i, input, NBLK_W: number of data blocks in the job; latched with start_i.
REQ-007 Port abort_i, input, 1: cancel the job in any state.
REQ-008 Ports wvalid_i, ivalid_i, cvalid_i, input, 1 each: key-word, IV and ciphertext source valid flags.
REQ-009 Port dst_ready_i, input, 1: the AES core accepts the mux output this cycle.
REQ-010 Port sel_o, output, 2: mux select (0 key, 1 IV, 2 ciphertext, 3 none).
REQ-011 Port busy_o, output, 1: high in every state except IDLE.
REQ-012 Port done_o, output, 1: one-cycle completion pulse.
REQ-013 Port blk_cnt_o, output, NBLK_W: number of blocks issued in the current or last job.

Function
REQ-014 The FSM SHALL have the states IDLE, KEY, IV, CHAIN and DRAIN, with sel_o driven combinationally from state as IDLE=3, KEY=0, IV=1, CHAIN=2 and DRAIN=2.
REQ-015 A transfer SHALL be the selected source's valid AND dst_ready_i in the same cycle; DRAIN ignores dst_ready_i and uses cvalid_i alone.
REQ-016 IDLE: on start_i with nblk_i!=0, latch nblk_i, clear blk_cnt_o and go to KEY next cycle.
REQ-017 IDLE: on start_i with nblk_i==0, pulse done_o next cycle and stay in IDLE.
REQ-018 KEY: on a transfer, go to IV.
REQ-019 IV: on a transfer, increment blk_cnt_o, then go to DRAIN if the latched nblk==1, otherwise go to CHAIN.
REQ-020 CHAIN: on a transfer, increment blk_cnt_o, then go to DRAIN if the new count equals nblk, otherwise stay in CHAIN.
REQ-021 DRAIN: on cvalid_i, pulse done_o for one cycle and go to IDLE.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 abort_i SHALL take priority over every transition: go to IDLE next cycle, no done_o pulse, blk_cnt_o holds its value.
REQ-024 blk_cnt_o arithmetic SHALL be unsigned NBLK_W-bit; nblk=2^NBLK_W-1 completes without overflow.
REQ-025 A valid that is held without dst_ready_i SHALL stall the state indefinitely and must not increment the count.

Reset
REQ-026 While rst_ni is low at a clock edge: state=IDLE, sel_o=3, busy_o=0, done_o=0, blk_cnt_o=0, latched nblk=0.
REQ-027 Reset mid-job SHALL discard the job without a done_o pulse.

Configuration
REQ-028 Macro AES_CBC_CHAIN_EN defined: CHAIN behaves as in REQ-020 (sel_o=2, cvalid_i; ciphertext feedback).
REQ-029 Macro AES_CBC_CHAIN_EN undefined: CHAIN drives sel_o=1 and transfers on ivalid_i AND dst_ready_i (a fresh IV per block); DRAIN is unchanged.

Structure
REQ-030 The shared package aes_pkg SHALL hold the select encoding (SEL_KEY=0, SEL_IV=1, SEL_CT=2, SEL_NONE=3) and the state enum.
REQ-031 The block SHALL be a single module with no sub-module; the instantiating level connects sel_o to the mux select.

Verification
REQ-032 Reset, then start_i with nblk=3, all valids and dst_ready_i high -> sel_o sequence 0,1,2,2,2, done_o on the 6th cycle after start, blk_cnt_o=3.
REQ-033 nblk=1 -> KEY, IV, DRAIN; done_o after the first cvalid_i; CHAIN never entered.
REQ-034 dst_ready_i low for 4 cycles in CHAIN with cvalid_i high -> state and count frozen; resumes when ready returns.
REQ-035 abort_i in CHAIN at blk_cnt=2 -> IDLE next cycle, sel_o=3, no done_o, blk_cnt_o=2; a new start_i then succeeds.
REQ-036 start_i with nblk=0 -> done_o one cycle later, busy_o never high; start_i asserted in IV -> ignored.
REQ-037 Build without AES_CBC_CHAIN_EN and nblk=2 -> sel_o sequence 0,1,1,2.
